mat4_loader: RTL
================

MAT4_LOADER -- requirements
Module: mat4_loader

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width in bits of one matrix element.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: clear  input  1  synchronous abort of a partial fill.
REQ-005 Port: in_valid  input  1  element offered on in_data.
REQ-006 Port: in_data  input  DATA_WIDTH  matrix element, row-major order, element 0 = row0/col0.
REQ-007 Port: in_ready  output  1  loader accepts an element this cycle.
REQ-008 Port: mat_valid  output  1  complete 4x4 matrix presented on mat_data.
REQ-009 Port: mat_data  output  16*DATA_WIDTH  flat matrix, element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port: mat_ready  input  1  determinant stage consumes the matrix.
REQ-011 Port: count  output  5  number of elements currently held, 0..16.

Function
REQ-012 The block SHALL implement two states: FILL and PRESENT.
REQ-013 In FILL, in_ready SHALL be 1 and mat_valid SHALL be 0.
REQ-014 In FILL, in_valid=1 SHALL store in_data into slot count and increment count by 1 in the same edge.
REQ-015 On accepting the 16th element (count 15 -> 16), the next state SHALL be PRESENT; mat_valid rises the following cycle (latency: 1 cycle after the last accept).
REQ-016 In PRESENT, in_ready SHALL be 0, mat_valid SHALL be 1, and mat_data SHALL be stable until the transfer completes.
REQ-017 A transfer SHALL complete on an edge where mat_valid=1 and mat_ready=1; count then becomes 0 and the state returns to FILL.
REQ-018 The block SHALL ignore in_valid while in_ready=0; no element is lost or stored.
REQ-019 Storage slots SHALL NOT be zeroed on transfer; mat_data content outside PRESENT is don't-care for consumers but deterministic.
REQ-020 clear=1 in FILL SHALL set count to 0 and override any simultaneous in_valid (element dropped).
REQ-021 clear=1 in PRESENT SHALL be ignored; a presented matrix is never withdrawn.
REQ-022 clear=1 with count=15 and in_valid=1 SHALL leave the state in FILL with count 0.
REQ-023 mat_ready while in FILL SHALL have no effect.
REQ-024 count SHALL never exceed 16 nor wrap; 16 is held only in PRESENT.
REQ-025 Back-to-back: the first element of the next matrix SHALL be acceptable in the cycle after transfer completes.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state FILL, count 0, mat_valid 0, in_ready 1 (in_ready follows state), all storage slots 0.
REQ-027 Reset asserted mid-fill or mid-PRESENT SHALL discard all held elements; no transfer completes during reset.
REQ-028 Release of rst_n SHALL be followed by normal FILL operation on the next rising edge.

Structure
REQ-029 A shared package mat_pkg SHALL hold N_ELEM=16, the FILL/PRESENT state encoding, and the default DATA_WIDTH.
REQ-030 Storage SHALL be 16 registers of DATA_WIDTH, flattened directly onto mat_data with no extra output register.
REQ-031 No sub-module is required; the 16-entry element store may optionally be the sub-module mat4_regfile (write-enable, 4-bit address, reset-to-zero).

Verification
REQ-032 Stream 1..16 with in_valid held, mat_ready=1 -> mat_valid one cycle after 16th accept for exactly 1 cycle, mat_data element k = k+1, count returns to 0.
REQ-033 Fill 16, hold mat_ready=0 for 10 cycles while in_valid=1 with value 0xAA -> in_ready=0, mat_data unchanged, count stays 16, no 0xAA stored.
REQ-034 Load 7 elements, pulse clear with in_valid=1 -> count 0; next 16 elements (0x10..0x1F) presented correctly with element 0 = 0x10.
REQ-035 Load 5 elements, assert rst_n=0 asynchronously between edges -> count, mat_valid, storage immediately 0; subsequent full load correct.
REQ-036 Two back-to-back matrices with mat_ready=1 constantly and in_valid=1 constantly -> 17-cycle period per matrix, both matrices delivered intact.
REQ-037 Random in_valid/mat_ready stalls over 1000 matrices against a scoreboard -> every accepted element appears in the correct slot, none dropped or duplicated.

Source files
------------

// File: rtl/mat_pkg.sv
// Shared definitions for the 4x4 matrix loader.
//   N_ELEM             : number of elements in one 4x4 matrix
//   DEFAULT_DATA_WIDTH : default element width in bits
//   state_t            : loader state encoding (FILL / PRESENT)
package mat_pkg;

    localparam int N_ELEM             = 16;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {
        ST_FILL    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/mat4_regfile.sv
// 16-entry element store for the matrix loader.
// Every slot is its own register so the whole matrix can be read in
// parallel as one flat vector; slots clear to zero on reset.
// Ports:
//   clk     : clock
//   rst_n   : asynchronous active-low reset, zeroes all slots
//   i_we    : write enable
//   i_addr  : slot index 0..15
//   i_wdata : element to write
//   o_flat  : all slots, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
module mat4_regfile
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_we,
    input  logic [3:0]                   i_addr,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    output logic [N_ELEM*DATA_WIDTH-1:0] o_flat
);

    genvar gi;
    generate
        for (gi = 0; gi < N_ELEM; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] r_slot;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_slot <= '0;
                end else if (i_we && (i_addr == 4'(gi))) begin
                    r_slot <= i_wdata;
                end
            end

            assign o_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_slot;
        end
    endgenerate

endmodule

// File: rtl/mat4_loader.sv
// Collects 16 row-major elements from a valid/ready stream and presents
// them as one flat 4x4 matrix to a downstream consumer.
// Ports:
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   clear     : abort a partial fill (ignored while presenting)
//   in_valid  : element offered on in_data
//   in_data   : matrix element, row-major
//   in_ready  : loader accepts an element this cycle (high in FILL)
//   mat_valid : complete matrix on mat_data (high in PRESENT)
//   mat_data  : flat matrix, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   mat_ready : consumer takes the matrix
//   count     : elements currently held, 0..16
module mat4_loader
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic                         mat_valid,
    output logic [N_ELEM*DATA_WIDTH-1:0] mat_data,
    input  logic                         mat_ready,
    output logic [4:0]                   count
);

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_count;
    logic [4:0] w_count_next;
    logic       w_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_we         = 1'b0;
        unique case (r_state)
            ST_FILL: begin
                // clear wins over a simultaneous element, even the 16th.
                if (clear) begin
                    w_count_next = '0;
                end else if (in_valid) begin
                    w_we         = 1'b1;
                    w_count_next = r_count + 5'd1;
                    if (r_count == 5'(N_ELEM - 1)) begin
                        w_state_next = ST_PRESENT;
                    end
                end
            end
            ST_PRESENT: begin
                // Only the consumer can retire a presented matrix.
                if (mat_ready) begin
                    w_state_next = ST_FILL;
                    w_count_next = '0;
                end
            end
            default: begin
                w_state_next = ST_FILL;
                w_count_next = '0;
            end
        endcase
    end

    // Slots are overwritten in place by the next fill; no zeroing on transfer.
    mat4_regfile #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_addr  (r_count[3:0]),
        .i_wdata (in_data),
        .o_flat  (mat_data)
    );

    assign in_ready  = (r_state == ST_FILL);
    assign mat_valid = (r_state == ST_PRESENT);
    assign count     = r_count;

endmodule
